// File: rtl/ace_ack_tracker.sv
// ACE RACK/WACK terminator: counts reads/writes from address handshake to acknowledge and throttles AR/AW at the limit.
// Full/idle/error are registered (one cycle after the causing edge); gating only masks valid downstream and ready upstream.

module ace_ack_side #(
    parameter int MaxTxn   = 8,
    parameter int CntWidth = $clog2(MaxTxn + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_addr_valid,
    input  logic                i_addr_ready,
    input  logic                i_done_hs,
    input  logic                i_ack,
    output logic                o_addr_valid,
    output logic                o_addr_ready,
    output logic [CntWidth-1:0] o_inflight,
    output logic [CntWidth-1:0] o_ackpend,
    output logic                o_err,
    output logic                o_empty_nxt
);

    localparam logic [CntWidth-1:0] LP_ONE = CntWidth'(1);
    localparam logic [CntWidth:0]   LP_MAX = (CntWidth + 1)'(MaxTxn);

    logic                r_full;
    logic                r_err;
    logic [CntWidth-1:0] r_inflight;
    logic [CntWidth-1:0] r_ackpend;

    logic                w_addr_hs;
    logic                w_inflight_zero;
    logic                w_ackpend_zero;
    logic                w_done_ok;
    logic                w_done_err;
    logic                w_ack_ok;
    logic                w_ack_err;
    logic [CntWidth-1:0] w_inflight_nxt;
    logic [CntWidth-1:0] w_ackpend_nxt;
    logic [CntWidth:0]   w_total_nxt;
    logic                w_full_nxt;

    assign o_addr_valid = i_addr_valid & ~r_full;
    assign o_addr_ready = i_addr_ready & ~r_full;
    assign w_addr_hs    = i_addr_valid & i_addr_ready & ~r_full;

    assign w_inflight_zero = (r_inflight == '0);
    assign w_ackpend_zero  = (r_ackpend == '0);

    // A completion racing the address handshake of an idle channel is legitimate.
    assign w_done_ok  = i_done_hs & (~w_inflight_zero | w_addr_hs);
    assign w_done_err = i_done_hs & w_inflight_zero & ~w_addr_hs;

    // The ack must trail the completion by a cycle, so only the registered count qualifies it.
    assign w_ack_ok  = i_ack & ~w_ackpend_zero;
    assign w_ack_err = i_ack & w_ackpend_zero;

    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_addr_hs, w_done_ok})
            2'b10:   w_inflight_nxt = r_inflight + LP_ONE;
            2'b01:   w_inflight_nxt = r_inflight - LP_ONE;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_comb begin
        w_ackpend_nxt = r_ackpend;
        case ({w_done_ok, w_ack_ok})
            2'b10:   w_ackpend_nxt = r_ackpend + LP_ONE;
            2'b01:   w_ackpend_nxt = r_ackpend - LP_ONE;
            default: w_ackpend_nxt = r_ackpend;
        endcase
    end

    assign w_total_nxt = {1'b0, w_inflight_nxt} + {1'b0, w_ackpend_nxt};
    assign w_full_nxt  = (w_total_nxt == LP_MAX);
    assign o_empty_nxt = (w_inflight_nxt == '0) & (w_ackpend_nxt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight <= '0;
            r_ackpend  <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_ackpend  <= w_ackpend_nxt;
            r_full     <= w_full_nxt;
            r_err      <= r_err | w_done_err | w_ack_err;
        end
    end

    assign o_inflight = r_inflight;
    assign o_ackpend  = r_ackpend;
    assign o_err      = r_err;

endmodule

module ace_ack_tracker #(
    parameter int MaxRdTxn   = 8,
    parameter int MaxWrTxn   = 8,
    parameter int RdCntWidth = $clog2(MaxRdTxn + 1),
    parameter int WrCntWidth = $clog2(MaxWrTxn + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slv_ar_valid_i,
    output logic                  slv_ar_ready_o,
    output logic                  mst_ar_valid_o,
    input  logic                  mst_ar_ready_i,
    input  logic                  slv_aw_valid_i,
    output logic                  slv_aw_ready_o,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    input  logic                  r_valid_i,
    input  logic                  r_ready_i,
    input  logic                  r_last_i,
    input  logic                  b_valid_i,
    input  logic                  b_ready_i,
    input  logic                  rack_i,
    input  logic                  wack_i,
    output logic [RdCntWidth-1:0] rd_inflight_o,
    output logic [RdCntWidth-1:0] rd_ackpend_o,
    output logic [WrCntWidth-1:0] wr_inflight_o,
    output logic [WrCntWidth-1:0] wr_ackpend_o,
    output logic                  rd_err_o,
    output logic                  wr_err_o,
    output logic                  idle_o
);

    logic w_rl_hs;
    logic w_b_hs;
    logic w_rd_empty_nxt;
    logic w_wr_empty_nxt;
    logic r_idle;

    // Non-last R beats carry no completion information.
    assign w_rl_hs = r_valid_i & r_ready_i & r_last_i;
    assign w_b_hs  = b_valid_i & b_ready_i;

    ace_ack_side #(
        .MaxTxn   (MaxRdTxn),
        .CntWidth (RdCntWidth)
    ) u_rd_side (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_addr_valid (slv_ar_valid_i),
        .i_addr_ready (mst_ar_ready_i),
        .i_done_hs    (w_rl_hs),
        .i_ack        (rack_i),
        .o_addr_valid (mst_ar_valid_o),
        .o_addr_ready (slv_ar_ready_o),
        .o_inflight   (rd_inflight_o),
        .o_ackpend    (rd_ackpend_o),
        .o_err        (rd_err_o),
        .o_empty_nxt  (w_rd_empty_nxt)
    );

    ace_ack_side #(
        .MaxTxn   (MaxWrTxn),
        .CntWidth (WrCntWidth)
    ) u_wr_side (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_addr_valid (slv_aw_valid_i),
        .i_addr_ready (mst_aw_ready_i),
        .i_done_hs    (w_b_hs),
        .i_ack        (wack_i),
        .o_addr_valid (mst_aw_valid_o),
        .o_addr_ready (slv_aw_ready_o),
        .o_inflight   (wr_inflight_o),
        .o_ackpend    (wr_ackpend_o),
        .o_err        (wr_err_o),
        .o_empty_nxt  (w_wr_empty_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= w_rd_empty_nxt & w_wr_empty_nxt;
        end
    end

    assign idle_o = r_idle;

endmodule

// File: tb/tb_ace_ack_tracker.sv
// Directed bench for ace_ack_tracker with a small reference model for the mixed-traffic phase.
// Checks are immediate assertions; failures are counted and summarised at the end.

module tb_ace_ack_tracker;

    localparam int MaxRd = 8;
    localparam int MaxWr = 8;
    localparam int RW    = $clog2(MaxRd + 1);
    localparam int WW    = $clog2(MaxWr + 1);

    logic clk_i = 1'b0;
    logic rst_i;
    logic slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
    logic slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
    logic r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i, rack_i, wack_i;
    logic [RW-1:0] rd_inflight_o, rd_ackpend_o;
    logic [WW-1:0] wr_inflight_o, wr_ackpend_o;
    logic rd_err_o, wr_err_o, idle_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ace_ack_tracker #(.MaxRdTxn(MaxRd), .MaxWrTxn(MaxWr)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
        .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .rack_i(rack_i), .wack_i(wack_i),
        .rd_inflight_o(rd_inflight_o), .rd_ackpend_o(rd_ackpend_o),
        .wr_inflight_o(wr_inflight_o), .wr_ackpend_o(wr_ackpend_o),
        .rd_err_o(rd_err_o), .wr_err_o(wr_err_o), .idle_o(idle_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int ri, input int ra, input int wi, input int wa);
        chk({tag, "_rd_inflight"}, 32'(rd_inflight_o), ri);
        chk({tag, "_rd_ackpend"},  32'(rd_ackpend_o),  ra);
        chk({tag, "_wr_inflight"}, 32'(wr_inflight_o), wi);
        chk({tag, "_wr_ackpend"},  32'(wr_ackpend_o),  wa);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        slv_ar_valid_i = 0; mst_ar_ready_i = 0; slv_aw_valid_i = 0; mst_aw_ready_i = 0;
        r_valid_i = 0; r_ready_i = 0; r_last_i = 0; b_valid_i = 0; b_ready_i = 0;
        rack_i = 0; wack_i = 0;
    endtask

    task automatic rlast(input logic v);
        r_valid_i = v; r_ready_i = v; r_last_i = v;
    endtask

    task automatic do_reset();
        clr();
        rst_i = 1;
        step();
        step();
        rst_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_ri, m_ra, m_wi, m_wa, rd_iss, wr_iss, cyc;
        logic m_rf, m_wf, arv, awv, ar_hs, aw_hs, rl, bh, ra, wa, done;

        // Reset values
        do_reset();
        chk_cnt("reset", 0, 0, 0, 0);
        chk("reset_rd_err", rd_err_o, 0);
        chk("reset_wr_err", wr_err_o, 0);
        chk("reset_idle", idle_o, 1);

        // Single read: AR, 4 beats with last on the 4th, RACK two cycles after
        slv_ar_valid_i = 1; mst_ar_ready_i = 1;
        #1;
        chk("single_ar_valid", mst_ar_valid_o, 1);
        chk("single_ar_ready", slv_ar_ready_o, 1);
        step();
        chk_cnt("single_ar", 1, 0, 0, 0);
        chk("single_busy", idle_o, 0);
        clr();
        r_valid_i = 1; r_ready_i = 1;
        repeat (3) step();
        chk("single_beats_ignored", 32'(rd_inflight_o), 1);
        r_last_i = 1;
        step();
        chk_cnt("single_rlast", 0, 1, 0, 0);
        clr();
        step();
        rack_i = 1;
        step();
        clr();
        chk_cnt("single_rack", 0, 0, 0, 0);
        chk("single_idle", idle_o, 1);
        chk("single_err", rd_err_o, 0);

        // Fill to MaxRd then reopen with one R last plus one RACK
        slv_ar_valid_i = 1; mst_ar_ready_i = 1;
        repeat (8) step();
        chk("fill_inflight", 32'(rd_inflight_o), 8);
        chk("fill_ar_valid_gated", mst_ar_valid_o, 0);
        chk("fill_ar_ready_gated", slv_ar_ready_o, 0);
        step();
        chk("fill_held", 32'(rd_inflight_o), 8);
        rlast(1);
        step();
        rlast(0);
        chk_cnt("fill_rlast", 7, 1, 0, 0);
        chk("fill_still_gated", mst_ar_valid_o, 0);
        rack_i = 1;
        step();
        rack_i = 0;
        chk_cnt("fill_rack", 7, 0, 0, 0);
        chk("reopen_ar_valid", mst_ar_valid_o, 1);
        chk("reopen_ar_ready", slv_ar_ready_o, 1);
        slv_ar_valid_i = 0;
        rlast(1);
        repeat (4) step();
        rlast(0);
        rack_i = 1;
        repeat (4) step();
        rack_i = 0;
        chk_cnt("drain_to3", 3, 0, 0, 0);

        // Simultaneous events
        slv_ar_valid_i = 1; rlast(1);
        step();
        slv_ar_valid_i = 0;
        chk_cnt("sim_ar_rl", 3, 1, 0, 0);
        step();
        chk_cnt("sim_rl", 2, 2, 0, 0);
        rack_i = 1;
        step();
        rack_i = 0;
        chk_cnt("sim_rl_rack", 1, 2, 0, 0);
        step();
        rlast(0);
        rack_i = 1;
        repeat (3) step();
        rack_i = 0;
        chk_cnt("sim_drained", 0, 0, 0, 0);
        chk("sim_idle", idle_o, 1);
        chk("sim_no_err", rd_err_o, 0);

        // R last racing the AR of an empty channel is legal
        slv_ar_valid_i = 1; rlast(1);
        step();
        clr();
        chk_cnt("race_ar_rl", 0, 1, 0, 0);
        chk("race_no_err", rd_err_o, 0);
        rack_i = 1;
        step();
        rack_i = 0;
        chk("race_rack", 32'(rd_ackpend_o), 0);

        // Errors
        rack_i = 1;
        step();
        rack_i = 0;
        chk("err_rack_set", rd_err_o, 1);
        chk("err_rack_cnt", 32'(rd_ackpend_o), 0);
        step();
        chk("err_rack_sticky", rd_err_o, 1);
        chk("err_wr_independent", wr_err_o, 0);
        b_valid_i = 1; b_ready_i = 1;
        step();
        clr();
        chk("err_b_set", wr_err_o, 1);
        chk_cnt("err_b", 0, 0, 0, 0);

        // WACK in the same cycle as the first B is premature
        do_reset();
        chk("err_cleared", wr_err_o, 0);
        slv_aw_valid_i = 1; mst_aw_ready_i = 1;
        step();
        clr();
        b_valid_i = 1; b_ready_i = 1; wack_i = 1;
        step();
        clr();
        chk_cnt("early_wack", 0, 0, 0, 1);
        chk("early_wack_err", wr_err_o, 1);
        do_reset();

        // Mixed traffic against a reference model
        m_ri = 0; m_ra = 0; m_wi = 0; m_wa = 0; m_rf = 0; m_wf = 0;
        rd_iss = 0; wr_iss = 0; cyc = 0; done = 0;
        while (!done && cyc < 2000) begin
            arv = (rd_iss < 3) && ($urandom_range(0, 1) == 1);
            awv = (wr_iss < 5) && ($urandom_range(0, 1) == 1);
            slv_ar_valid_i = arv; mst_ar_ready_i = 1'($urandom_range(0, 1));
            slv_aw_valid_i = awv; mst_aw_ready_i = 1'($urandom_range(0, 1));
            r_valid_i = 1'($urandom_range(0, 1)); r_ready_i = 1'($urandom_range(0, 1));
            r_last_i = (m_ri > 0) && ($urandom_range(0, 1) == 1);
            bh = (m_wi > 0) && ($urandom_range(0, 1) == 1);
            b_valid_i = bh; b_ready_i = bh;
            rack_i = (m_ra > 0) && ($urandom_range(0, 2) == 0);
            wack_i = (m_wa > 0) && ($urandom_range(0, 2) == 0);
            #1;
            chk("mix_ar_gate", mst_ar_valid_o, arv & ~m_rf);
            chk("mix_aw_gate", mst_aw_valid_o, awv & ~m_wf);
            ar_hs = arv & mst_ar_ready_i & ~m_rf;
            aw_hs = awv & mst_aw_ready_i & ~m_wf;
            rl = r_valid_i & r_ready_i & r_last_i;
            ra = rack_i; wa = wack_i;
            m_ri = m_ri + int'(ar_hs) - int'(rl);
            m_ra = m_ra + int'(rl) - int'(ra);
            m_wi = m_wi + int'(aw_hs) - int'(bh);
            m_wa = m_wa + int'(bh) - int'(wa);
            m_rf = (m_ri + m_ra == MaxRd);
            m_wf = (m_wi + m_wa == MaxWr);
            rd_iss += int'(ar_hs);
            wr_iss += int'(aw_hs);
            step();
            chk_cnt("mix", m_ri, m_ra, m_wi, m_wa);
            chk("mix_idle", idle_o, (m_ri + m_ra + m_wi + m_wa) == 0);
            done = (rd_iss == 3) && (wr_iss == 5) && (m_ri + m_ra + m_wi + m_wa == 0);
            cyc++;
        end
        clr();
        chk("mix_completed", done, 1);
        chk("mix_final_idle", idle_o, 1);
        chk("mix_rd_err", rd_err_o, 0);
        chk("mix_wr_err", wr_err_o, 0);

        // Reset mid-operation
        slv_ar_valid_i = 1; mst_ar_ready_i = 1;
        repeat (8) step();
        slv_ar_valid_i = 0;
        rlast(1);
        repeat (4) step();
        rlast(0);
        slv_aw_valid_i = 1; mst_aw_ready_i = 1;
        repeat (2) step();
        slv_aw_valid_i = 0;
        b_valid_i = 1; b_ready_i = 1;
        repeat (3) step();
        b_valid_i = 0; b_ready_i = 0;
        slv_ar_valid_i = 1;
        #1;
        chk_cnt("pre_rst", 4, 4, 0, 2);
        chk("pre_rst_wr_err", wr_err_o, 1);
        chk("pre_rst_gated", mst_ar_valid_o, 0);
        rst_i = 1;
        step();
        rst_i = 0;
        chk_cnt("mid_rst", 0, 0, 0, 0);
        chk("mid_rst_rd_err", rd_err_o, 0);
        chk("mid_rst_wr_err", wr_err_o, 0);
        chk("mid_rst_idle", idle_o, 1);
        chk("mid_rst_ar_valid", mst_ar_valid_o, 1);
        chk("mid_rst_ar_ready", slv_ar_ready_o, 1);
        clr();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ace_ack_tracker.md
Name: ace_ack_tracker

Overview:
- Sits on the slave (interconnect) side of an ACE link and terminates the master's RACK/WACK acknowledge signalling.
- Counts reads and writes from address handshake through to their acknowledge.
- Throttles new AR/AW issue when the number of unacknowledged transactions reaches a limit.
- Flags protocol violations: an acknowledge with nothing pending, or a completion with nothing in flight.

Parameters:
- MaxRdTxn, 8, max reads between AR handshake and RACK; must be ≥1.
- MaxWrTxn, 8, max writes between AW handshake and WACK; must be ≥1.
- RdCntWidth, $clog2(MaxRdTxn+1), derived; width of read counters.
- WrCntWidth, $clog2(MaxWrTxn+1), derived; width of write counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- slv_ar_valid_i  in  1  AR valid from master.
- slv_ar_ready_o  out  1  AR ready to master.
- mst_ar_valid_o  out  1  AR valid toward memory side.
- mst_ar_ready_i  in  1  AR ready from memory side.
- slv_aw_valid_i  in  1  AW valid from master.
- slv_aw_ready_o  out  1  AW ready to master.
- mst_aw_valid_o  out  1  AW valid toward memory side.
- mst_aw_ready_i  in  1  AW ready from memory side.
- r_valid_i, r_ready_i, r_last_i  in  1 each  observed R channel, monitor only.
- b_valid_i, b_ready_i  in  1 each  observed B channel, monitor only.
- rack_i  in  1  RACK from master.
- wack_i  in  1  WACK from master.
- rd_inflight_o  out  RdCntWidth  reads accepted with R last not yet seen.
- rd_ackpend_o  out  RdCntWidth  reads with R last done, RACK not yet seen.
- wr_inflight_o  out  WrCntWidth  writes accepted with B not yet seen.
- wr_ackpend_o  out  WrCntWidth  writes with B done, WACK not yet seen.
- rd_err_o  out  1  sticky read protocol error.
- wr_err_o  out  1  sticky write protocol error.
- idle_o  out  1  all four counters are zero.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: all counters 0, rd_err_o=0, wr_err_o=0, idle_o=1, rd_full=0, wr_full=0.
- Reset asserted mid-operation clears all counters and errors at the next edge regardless of traffic; outstanding transactions are forgotten.
- Full flags are registered:
  - rd_full = (next rd_inflight + next rd_ackpend == MaxRdTxn).
  - wr_full is the same using the write counters and MaxWrTxn.
- Gating is combinational from registered full:
  - mst_ar_valid_o = slv_ar_valid_i & ~rd_full.
  - slv_ar_ready_o = mst_ar_ready_i & ~rd_full.
  - AW is gated identically with wr_full.
- Gating never drops a valid mid-handshake: while full, valid is held low downstream and ready low upstream.
- Events per cycle:
  - ar_hs = mst_ar_valid_o & mst_ar_ready_i.
  - rl_hs = r_valid_i & r_ready_i & r_last_i.
  - aw_hs and b_hs are formed the same way (b_hs = b_valid_i & b_ready_i).
- rd_inflight: +1 on ar_hs, −1 on rl_hs; both in one cycle leaves it unchanged.
- rl_hs with rd_inflight==0 and no ar_hs in the same cycle:
  - rd_err_o set.
  - rd_inflight unchanged; rd_ackpend not incremented.
- rd_ackpend: +1 on a valid rl_hs, −1 on rack_i; both in one cycle leaves it unchanged.
- rack_i with rd_ackpend==0 sets rd_err_o, counter unchanged.
  - This includes rack_i in the same cycle as the first rl_hs, since RACK must follow the R last handshake by ≥1 cycle.
- Write side mirrors the read side with aw_hs/b_hs/wack_i; its errors set wr_err_o.
- R beats without r_last_i are ignored.
- Errors are sticky until reset.
- Counters never wrap:
  - Increment is impossible at max because of gating.
  - Decrement at 0 is the error case and leaves the counter at 0.
- Latency: the full flag updates one cycle after the handshake that fills it; no combinational path from rack_i/wack_i to ready.
- idle_o is registered: 1 when all four counters are 0 after the edge.
- Read and write paths are fully independent.

Test Plan:
- Reset, then single read: AR handshake, R len=3 with last on beat 4, RACK 2 cycles later.
  - rd_inflight_o goes 1→0, rd_ackpend_o goes 0→1→0.
  - idle_o returns to 1; rd_err_o=0.
- Fill: MaxRdTxn=8, issue 8 ARs with mst_ar_ready_i=1.
  - After the 8th, slv_ar_ready_o=0 and mst_ar_valid_o=0.
  - One R last plus one RACK reopens AR on the following cycle.
- Simultaneous events: ar_hs and rl_hs in the same cycle with rd_inflight_o=3 → stays 3, rd_ackpend_o +1.
  - rl_hs and rack_i together with ackpend=2 → ackpend stays 2.
- Errors:
  - rack_i with rd_ackpend_o=0 → rd_err_o=1 next cycle and stays 1.
  - B handshake with wr_inflight_o=0 → wr_err_o=1; counters remain 0.
- Mixed traffic: 5 writes and 3 reads interleaved with random ready/ack delays, then all acknowledged.
  - Counters track a reference model every cycle; finish idle_o=1 with no errors.
- Reset mid-operation: rst_i for 1 cycle with rd_inflight_o=4 and wr_ackpend_o=2.
  - All counters 0, errors 0, gating released the next cycle.
